i2c_rx_ctrl: RTL



---
 rtl/i2c_rx_pkg.sv | 20 ++
 rtl/i2c_rx_ctrl_if.sv | 35 +++
 rtl/i2c_rx_shift.sv | 36 +++
 rtl/i2c_rx_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_rx_pkg.sv
// Shared encodings for the I2C receive sequencer: FSM state codes,
// SDA drive levels for the ACK bit, and the byte width.
package i2c_rx_pkg;

    localparam int BYTE_BITS = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_SHIFT    = 3'd1;
    localparam state_t ST_ACK_WAIT = 3'd2;
    localparam state_t ST_STALL    = 3'd3;
    localparam state_t ST_ACK      = 3'd4;
    localparam state_t ST_DONE     = 3'd5;

    // sda_oe level during the ACK bit: pulling SDA low acknowledges.
    localparam logic ACK  = 1'b1;
    localparam logic NACK = 1'b0;

endpackage

// File: rtl/i2c_rx_ctrl_if.sv
// Signal bundle between the receive sequencer and its surroundings
// (APB register block, bit-timing generator, RX FIFO).
// slave  : the sequencer itself.
// master : the environment driving it.
interface i2c_rx_ctrl_if
    import i2c_rx_pkg::*;
#(
    parameter int LEN_W = 8
);
    logic                 rx_start;
    logic [LEN_W-1:0]     rx_len;
    logic                 rx_abort;
    logic                 scl_rise;
    logic                 scl_fall;
    logic                 sda_in;
    logic                 rxff_full;
    logic                 i_rxff_wr;
    logic [BYTE_BITS-1:0] rxff_din;
    logic                 sda_oe;
    logic                 scl_hold;
    logic                 rx_busy;
    logic                 rx_done;
    logic                 rx_err;

    modport slave (
        input  rx_start, rx_len, rx_abort, scl_rise, scl_fall, sda_in, rxff_full,
        output i_rxff_wr, rxff_din, sda_oe, scl_hold, rx_busy, rx_done, rx_err
    );

    modport master (
        output rx_start, rx_len, rx_abort, scl_rise, scl_fall, sda_in, rxff_full,
        input  i_rxff_wr, rxff_din, sda_oe, scl_hold, rx_busy, rx_done, rx_err
    );

endinterface

// File: rtl/i2c_rx_shift.sv
// MSB-first SDA deserializer with a bit counter. byte_rdy is high while
// the next shift will complete the byte, so the FSM can leave SHIFT on
// the same strobe that captures bit 0.
module i2c_rx_shift
    import i2c_rx_pkg::*;
(
    input  logic                 pclk,
    input  logic                 prst_n,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic                 sda_in,
    output logic [BYTE_BITS-1:0] shreg,
    output logic                 byte_rdy
);

    logic [3:0] bit_cnt;

    assign byte_rdy = (bit_cnt == 4'(BYTE_BITS - 1));

    // Shift one SDA bit in per enabled SCL rise; clear restarts the byte.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shreg   <= {shreg[BYTE_BITS-2:0], sda_in};
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/i2c_rx_ctrl.sv
// I2C receive sequencer: deserializes bytes, writes them to the RX FIFO,
// drives ACK/NACK, and reports done/error to the register block.
// Optional: define I2C_RX_STRETCH_EN to stretch SCL on a full FIFO
// instead of dropping the byte and NACKing.
module i2c_rx_ctrl
    import i2c_rx_pkg::*;
#(
    parameter int LEN_W = 8
)(
    input  logic          pclk,
    input  logic          prst_n,
    i2c_rx_ctrl_if.slave  bus
);

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic                 ovf_q, ovf_d;

    logic                 sh_clear, sh_en, byte_rdy;
    logic [BYTE_BITS-1:0] shreg;
    logic                 ack_lvl;

    logic                 wr_q, wr_d;
    logic [BYTE_BITS-1:0] din_q, din_d;
    logic                 sda_q, sda_d;
    logic                 hold_q, hold_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    i2c_rx_shift u_shift (
        .pclk     (pclk),
        .prst_n   (prst_n),
        .clear    (sh_clear),
        .shift_en (sh_en),
        .sda_in   (bus.sda_in),
        .shreg    (shreg),
        .byte_rdy (byte_rdy)
    );

    // Last byte of the transfer is NACKed so the transmitter releases SDA.
    assign ack_lvl = (rem_q != LEN_W'(1)) ? ACK : NACK;

    // State and registered-output flops.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            wr_q    <= 1'b0;
            din_q   <= '0;
            sda_q   <= 1'b0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            din_q   <= din_d;
            sda_q   <= sda_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state, byte counter and shifter control; abort wins over all.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_d  = state_q;
        rem_d    = rem_q;
        ovf_d    = ovf_q;
        sh_clear = 1'b0;
        sh_en    = 1'b0;
        if (bus.rx_abort) begin
            state_d  = ST_IDLE;
            sh_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_start && (bus.rx_len != '0)) begin
                        state_d  = ST_SHIFT;
                        rem_d    = bus.rx_len;
                        ovf_d    = 1'b0;
                        sh_clear = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (bus.scl_rise) begin
                        sh_en = 1'b1;
                        if (byte_rdy) state_d = ST_ACK_WAIT;
                    end
                end
                ST_ACK_WAIT: begin
                    if (bus.scl_fall) begin
                        if (!bus.rxff_full) begin
                            state_d = ST_ACK;
                        end else begin
`ifdef I2C_RX_STRETCH_EN
                            state_d = ST_STALL;
`else
                            ovf_d   = 1'b1;
                            state_d = ST_ACK;
`endif
                        end
                    end
                end
`ifdef I2C_RX_STRETCH_EN
                ST_STALL: begin
                    if (!bus.rxff_full) state_d = ST_ACK;
                end
`endif
                ST_ACK: begin
                    if (bus.scl_fall) begin
                        rem_d = rem_q - LEN_W'(1);
                        if ((rem_q == LEN_W'(1)) || ovf_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d  = ST_SHIFT;
                            sh_clear = 1'b1;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; pulses default low.
    always_comb begin
        wr_d   = 1'b0;
        din_d  = din_q;
        sda_d  = sda_q;
        hold_d = hold_q;
        busy_d = busy_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        if (bus.rx_abort) begin
            if (state_q != ST_IDLE) begin
                sda_d  = NACK;
                hold_d = 1'b0;
                busy_d = 1'b0;
                err_d  = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_start) begin
                        if (bus.rx_len != '0) busy_d = 1'b1;
                        else                  done_d = 1'b1;
                    end
                end
                ST_ACK_WAIT: begin
                    if (bus.scl_fall) begin
                        if (!bus.rxff_full) begin
                            wr_d  = 1'b1;
                            din_d = shreg;
                            sda_d = ack_lvl;
                        end else begin
`ifdef I2C_RX_STRETCH_EN
                            hold_d = 1'b1;
`else
                            sda_d  = NACK;
`endif
                        end
                    end
                end
`ifdef I2C_RX_STRETCH_EN
                ST_STALL: begin
                    if (!bus.rxff_full) begin
                        hold_d = 1'b0;
                        wr_d   = 1'b1;
                        din_d  = shreg;
                        sda_d  = ack_lvl;
                    end
                end
`endif
                ST_ACK: begin
                    if (bus.scl_fall) sda_d = NACK;
                end
                ST_DONE: begin
                    done_d = !ovf_q;
                    err_d  = ovf_q;
                    busy_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.i_rxff_wr = wr_q;
    assign bus.rxff_din  = din_q;
    assign bus.sda_oe    = sda_q;
    assign bus.scl_hold  = hold_q;
    assign bus.rx_busy   = busy_q;
    assign bus.rx_done   = done_q;
    assign bus.rx_err    = err_q;

endmodule
